cell_frame_buffer: RTL and testbench

// Memory-side responder for cells_next_state: serves its read requests from the front cell bank and

---
 rtl/cell_frame_buffer.sv | 107 ++++++++++
 tb/tb_cell_frame_buffer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/cell_frame_buffer.sv
// Ping-pong cell store between the next-state engine and the VGA pixel path.
// The engine reads the front bank and writes the back bank; banks swap at the first frame start after done.
module cell_frame_buffer #(
    parameter int ACTIVE_COLUMNS = 640,
    parameter int ACTIVE_ROWS    = 480,
    parameter int ADDR_WIDTH     = $clog2(ACTIVE_COLUMNS * ACTIVE_ROWS),
    parameter int DATA_WIDTH     = 1
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic [ADDR_WIDTH-1:0] sim_rd_address_i,
    output logic [DATA_WIDTH-1:0] sim_pixel_o,
    input  logic [ADDR_WIDTH-1:0] sim_wr_address_i,
    input  logic [DATA_WIDTH-1:0] sim_wr_data_i,
    input  logic                  sim_wr_en_i,
    input  logic                  sim_done_i,
    output logic                  sim_ready_o,
    input  logic [ADDR_WIDTH-1:0] vga_rd_address_i,
    output logic [DATA_WIDTH-1:0] vga_pixel_o,
    input  logic                  frame_start_i,
    output logic [15:0]           generation_o
);

    localparam int N = ACTIVE_COLUMNS * ACTIVE_ROWS;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(N - 1);

    typedef enum logic [1:0] {S_CLEAR, S_READY, S_RUN, S_WAIT} state_t;

    state_t                  state;
    state_t                  state_next;
    logic [ADDR_WIDTH-1:0]   clear_addr;
    logic                    bank_sel;
    logic                    wr_accept;
    logic                    swap;
    logic [DATA_WIDTH-1:0]   bank0 [N];
    logic [DATA_WIDTH-1:0]   bank1 [N];

    always_comb begin
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        state_next  = state;
        sim_ready_o = 1'b0;
        wr_accept   = 1'b0;
        swap        = 1'b0;
        case (state)
            S_CLEAR: if (clear_addr == LAST_ADDR) state_next = S_READY;
            S_READY: begin
                sim_ready_o = 1'b1;
                state_next  = S_RUN;
            end
            S_RUN: begin
                wr_accept = sim_wr_en_i && (sim_wr_address_i <= LAST_ADDR);
                if (sim_done_i) state_next = S_WAIT;
            end
            S_WAIT: if (frame_start_i) begin
                swap       = 1'b1;
                state_next = S_READY;
            end
            default: state_next = S_CLEAR;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state        <= S_CLEAR;
            clear_addr   <= '0;
            bank_sel     <= 1'b0;
            generation_o <= '0;
        end else begin
            state <= state_next;
            if (state == S_CLEAR && clear_addr != LAST_ADDR)
                clear_addr <= clear_addr + ADDR_WIDTH'(1);
            if (swap) begin
                bank_sel     <= ~bank_sel;
                generation_o <= generation_o + 16'd1;
            end
        end
    end

    // NOTE: the banks have no reset; the S_CLEAR sweep zeroes them, keeping them mappable to block RAM.
    always_ff @(posedge clk_i) begin
        if (state == S_CLEAR) begin
            bank0[clear_addr] <= '0;
            bank1[clear_addr] <= '0;
        end else if (wr_accept) begin
            if (bank_sel) bank0[sim_wr_address_i] <= sim_wr_data_i;
            else          bank1[sim_wr_address_i] <= sim_wr_data_i;
        end
    end

    // Front-bank lookup shared by both read ports; out-of-range and mid-clear reads give zero.
    function automatic logic [DATA_WIDTH-1:0] front_word(input logic [ADDR_WIDTH-1:0] addr);
        if (state == S_CLEAR || addr > LAST_ADDR) return '0;
        return bank_sel ? bank1[addr] : bank0[addr];
    endfunction

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            sim_pixel_o <= '0;
            vga_pixel_o <= '0;
        end else begin
            sim_pixel_o <= front_word(sim_rd_address_i);
            vga_pixel_o <= front_word(vga_rd_address_i);
        end
    end

endmodule

// File: tb/tb_cell_frame_buffer.sv
// Directed bench for cell_frame_buffer on a 4x3 grid (12 cells).
// Inputs change and outputs are sampled on the falling edge.
module tb_cell_frame_buffer;

    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          reset_i = 1'b0;
    logic [AW-1:0] sim_rd_address = '0;
    logic          sim_pixel;
    logic [AW-1:0] sim_wr_address = '0;
    logic          sim_wr_data = 1'b0;
    logic          sim_wr_en = 1'b0;
    logic          sim_done = 1'b0;
    logic          sim_ready;
    logic [AW-1:0] vga_rd_address = '0;
    logic          vga_pixel;
    logic          frame_start = 1'b0;
    logic [15:0]   generation;

    int checks = 0;
    int errors = 0;
    int cyc;

    always #5 clk = ~clk;

    cell_frame_buffer #(
        .ACTIVE_COLUMNS(4),
        .ACTIVE_ROWS   (3),
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (1)
    ) dut (
        .clk_i           (clk),
        .reset_i         (reset_i),
        .sim_rd_address_i(sim_rd_address),
        .sim_pixel_o     (sim_pixel),
        .sim_wr_address_i(sim_wr_address),
        .sim_wr_data_i   (sim_wr_data),
        .sim_wr_en_i     (sim_wr_en),
        .sim_done_i      (sim_done),
        .sim_ready_o     (sim_ready),
        .vga_rd_address_i(vga_rd_address),
        .vga_pixel_o     (vga_pixel),
        .frame_start_i   (frame_start),
        .generation_o    (generation)
    );

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic read_both(input int addr, input logic expected, input string tag);
        sim_rd_address = AW'(addr);
        vga_rd_address = AW'(addr);
        tick();
        check($sformatf("%s_sim[%0d]", tag, addr), 32'(sim_pixel), 32'(expected));
        check($sformatf("%s_vga[%0d]", tag, addr), 32'(vga_pixel), 32'(expected));
    endtask

    task automatic write_cell(input int addr, input logic data);
        sim_wr_address = AW'(addr);
        sim_wr_data    = data;
        sim_wr_en      = 1'b1;
        tick();
        sim_wr_en      = 1'b0;
    endtask

    task automatic pulse_done();
        sim_done = 1'b1;
        tick();
        sim_done = 1'b0;
    endtask

    task automatic pulse_frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    // Counts falling edges since reset release until the ready pulse; cycle number = edges + 1.
    task automatic wait_ready(input int elapsed, output int cycle_no);
        int  n     = elapsed;
        bit  found = 1'b0;
        while (!found && n < 100) begin
            tick();
            n++;
            if (sim_ready) found = 1'b1;
        end
        check("ready_seen", 32'(found), 32'd1);
        cycle_no = n + 1;
    endtask

    initial begin
        // 1: reset state, clear sweep, first ready pulse, all cells zero
        repeat (3) tick();
        check("rst_sim_pixel", 32'(sim_pixel), 32'd0);
        check("rst_vga_pixel", 32'(vga_pixel), 32'd0);
        check("rst_ready", 32'(sim_ready), 32'd0);
        check("rst_generation", 32'(generation), 32'd0);
        reset_i = 1'b1;
        wait_ready(0, cyc);
        check("first_ready_cycle", 32'(cyc), 32'd13);
        tick();
        check("ready_one_cycle", 32'(sim_ready), 32'd0);
        for (int a = 0; a < 12; a++) read_both(a, 1'b0, "cleared");

        // 2: writes land in the back bank, visible only after done + frame start
        write_cell(5, 1'b1);
        write_cell(11, 1'b1);
        read_both(5, 1'b0, "pre_swap");
        pulse_done();
        check("wait_gen0", 32'(generation), 32'd0);
        check("wait_ready0", 32'(sim_ready), 32'd0);
        pulse_frame();
        check("swap1_gen", 32'(generation), 32'd1);
        check("swap1_ready", 32'(sim_ready), 32'd1);
        read_both(5, 1'b1, "swap1");
        read_both(11, 1'b1, "swap1");
        read_both(4, 1'b0, "swap1");

        // 3: out-of-range writes are dropped and out-of-range reads return zero
        write_cell(12, 1'b1);
        write_cell(15, 1'b1);
        read_both(12, 1'b0, "oor_read");
        pulse_done();
        pulse_frame();
        check("swap2_gen", 32'(generation), 32'd2);
        for (int a = 0; a < 12; a++) read_both(a, 1'b0, "oor_bank");

        // 4: frame start in the done cycle does not swap; a later one does
        write_cell(0, 1'b1);
        sim_done    = 1'b1;
        frame_start = 1'b1;
        tick();
        sim_done    = 1'b0;
        frame_start = 1'b0;
        check("coincident_gen", 32'(generation), 32'd2);
        check("coincident_ready", 32'(sim_ready), 32'd0);
        repeat (2) tick();
        check("still_waiting_gen", 32'(generation), 32'd2);
        read_both(0, 1'b0, "no_swap");
        pulse_frame();
        check("swap3_gen", 32'(generation), 32'd3);
        check("swap3_ready", 32'(sim_ready), 32'd1);

        // 5: done in S_READY / S_WAIT, frame start in S_RUN and writes in S_WAIT are ignored
        pulse_done();
        check("done_in_ready", 32'(sim_ready), 32'd0);
        read_both(0, 1'b1, "swap3");
        read_both(5, 1'b1, "swap3");
        pulse_frame();
        check("frame_in_run_gen", 32'(generation), 32'd3);
        write_cell(3, 1'b1);
        pulse_done();
        write_cell(7, 1'b1);
        pulse_done();
        check("done_in_wait_gen", 32'(generation), 32'd3);
        check("done_in_wait_ready", 32'(sim_ready), 32'd0);
        pulse_frame();
        check("swap4_gen", 32'(generation), 32'd4);
        for (int a = 0; a < 12; a++) read_both(a, (a == 3), "swap4");

        // 6: reset in the middle of S_RUN aborts everything and restarts the clear
        write_cell(2, 1'b1);
        pulse_done();
        pulse_frame();
        check("swap5_gen", 32'(generation), 32'd5);
        tick();
        read_both(2, 1'b1, "pre_reset");
        #2 reset_i = 1'b0;
        sim_rd_address = AW'(3);
        vga_rd_address = AW'(3);
        #1;
        check("async_rst_sim_pixel", 32'(sim_pixel), 32'd0);
        check("async_rst_vga_pixel", 32'(vga_pixel), 32'd0);
        check("async_rst_generation", 32'(generation), 32'd0);
        check("async_rst_ready", 32'(sim_ready), 32'd0);
        repeat (2) tick();
        reset_i = 1'b1;
        repeat (2) tick();
        check("clearing_sim_pixel", 32'(sim_pixel), 32'd0);
        check("clearing_vga_pixel", 32'(vga_pixel), 32'd0);
        wait_ready(2, cyc);
        check("rerun_ready_cycle", 32'(cyc), 32'd13);
        check("rerun_generation", 32'(generation), 32'd0);
        tick();
        for (int a = 0; a < 12; a++) read_both(a, 1'b0, "recleared");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
